// File: rtl/board_manager.sv
// Board RAM manager: copies the maze ROM on a reload edge, counts dots/pellets,
// services eat requests and serves renderer reads. Optional score output under BOARD_SCORE_EN.
module board_manager #(
    parameter int COLS   = 28,
    parameter int ROWS   = 31,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_board_reload,
    output logic              o_board_reload_done,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [1:0]        i_rom_data,
    input  logic              i_eat_valid,
    input  logic [4:0]        i_eat_col,
    input  logic [4:0]        i_eat_row,
    output logic              o_eat_ready,
    output logic              o_eat_dot,
    output logic              o_eat_pellet,
    output logic [CNT_W-1:0]  o_dots_left,
    output logic              o_dot_clear,
    input  logic [4:0]        i_rd_col,
    input  logic [4:0]        i_rd_row,
    output logic [1:0]        o_rd_tile
`ifdef BOARD_SCORE_EN
   ,output logic [15:0]       o_score
`endif
);
    localparam int N = COLS * ROWS;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

    typedef enum logic [2:0] {IDLE, LOAD, FINISH, ACTIVE, EAT_RD, EAT_CHK} state_t;
    state_t state_reg, state_next;

    logic              reload_d_reg;
    logic              reload_rise;
    logic [1:0]        ram [N];
    logic [ADDR_W-1:0] rom_addr_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic              wr_en_reg;
    logic [ADDR_W-1:0] eat_addr_reg;
    logic              eat_oor_reg;
    logic [1:0]        eat_tile_reg;
    logic [CNT_W-1:0]  dots_reg;
    logic [1:0]        rd_tile_reg;
    logic              last_write;
    logic              eat_hit;

    function automatic logic in_range(input logic [4:0] col, input logic [4:0] row);
        return (int'(col) < COLS) && (int'(row) < ROWS);
    endfunction

    function automatic logic [ADDR_W-1:0] tile_addr(input logic [4:0] col, input logic [4:0] row);
        return ADDR_W'(int'(row) * COLS + int'(col));
    endfunction

    assign reload_rise = i_board_reload & ~reload_d_reg;
    // The final ROM word lands one cycle after its address, so LOAD ends on that write.
    assign last_write  = wr_en_reg && (wr_addr_reg == LAST_ADDR);
    assign eat_hit     = (state_reg == EAT_CHK) && !eat_oor_reg && eat_tile_reg[1] && !reload_rise;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= IDLE;
            reload_d_reg <= 1'b0;
            rom_addr_reg <= '0;
            wr_addr_reg  <= '0;
            wr_en_reg    <= 1'b0;
            dots_reg     <= '0;
            eat_addr_reg <= '0;
            eat_oor_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            reload_d_reg <= i_board_reload;
            wr_addr_reg  <= rom_addr_reg;
            if (reload_rise) begin
                rom_addr_reg <= '0;
                wr_en_reg    <= 1'b0;
                dots_reg     <= '0;
            end else begin
                wr_en_reg <= (state_reg == LOAD) && !last_write;
                if (state_reg == LOAD && rom_addr_reg != LAST_ADDR)
                    rom_addr_reg <= rom_addr_reg + 1'b1;
                if (wr_en_reg && i_rom_data[1])
                    dots_reg <= dots_reg + 1'b1;
                else if (eat_hit && dots_reg != '0)
                    dots_reg <= dots_reg - 1'b1;
                if (state_reg == ACTIVE && i_eat_valid) begin
                    // Out-of-range requests park on address 0 and are flagged as empty.
                    eat_oor_reg  <= !in_range(i_eat_col, i_eat_row);
                    eat_addr_reg <= in_range(i_eat_col, i_eat_row) ?
                                    tile_addr(i_eat_col, i_eat_row) : '0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en_reg)
            ram[wr_addr_reg] <= i_rom_data;
        else if (eat_hit)
            ram[eat_addr_reg] <= 2'd0;
        if (state_reg == EAT_RD)
            eat_tile_reg <= ram[eat_addr_reg];
    end

    // Read-before-write: a renderer read colliding with an eat write sees the old tile.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            rd_tile_reg <= 2'd0;
        else
            rd_tile_reg <= in_range(i_rd_col, i_rd_row) ? ram[tile_addr(i_rd_col, i_rd_row)] : 2'd0;
    end

    always_comb begin
        state_next          = state_reg;
        o_board_reload_done = 1'b0;
        o_eat_ready         = 1'b0;
        o_eat_dot           = 1'b0;
        o_eat_pellet        = 1'b0;
        o_dot_clear         = 1'b0;
        case (state_reg)
            IDLE:    state_next = IDLE;
            LOAD:    if (last_write) state_next = FINISH;
            FINISH: begin
                o_board_reload_done = 1'b1;
                state_next          = ACTIVE;
            end
            ACTIVE: begin
                o_eat_ready = 1'b1;
                o_dot_clear = (dots_reg == '0);
                if (i_eat_valid) state_next = EAT_RD;
            end
            EAT_RD: begin
                o_dot_clear = (dots_reg == '0);
                state_next  = EAT_CHK;
            end
            EAT_CHK: begin
                o_dot_clear  = (dots_reg == '0);
                o_eat_dot    = eat_hit && !eat_tile_reg[0];
                o_eat_pellet = eat_hit &&  eat_tile_reg[0];
                state_next   = ACTIVE;
            end
            default: state_next = IDLE;
        endcase
        if (reload_rise) state_next = LOAD;
    end

    assign o_rom_addr  = rom_addr_reg;
    assign o_dots_left = dots_reg;
    assign o_rd_tile   = rd_tile_reg;

`ifdef BOARD_SCORE_EN
    logic [15:0] score_reg;
    logic [16:0] score_sum;

    assign score_sum = {1'b0, score_reg} + (o_eat_pellet ? 17'd50 : (o_eat_dot ? 17'd10 : 17'd0));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            score_reg <= 16'd0;
        else
            score_reg <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end

    assign o_score = score_reg;
`endif
endmodule

// File: tb/tb_board_manager.sv
// Scoreboard bench for board_manager: stimulus pushes expectations computed from a
// tile-array model of the board; a negedge monitor pops and compares on DUT outputs.
module tb_board_manager;
    localparam int COLS = 28;
    localparam int ROWS = 31;
    localparam int N    = COLS * ROWS;

    logic       clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_board_reload = 1'b0;
    logic       o_board_reload_done;
    logic [9:0] o_rom_addr;
    logic [1:0] rom_data = 2'd0;
    logic       i_eat_valid = 1'b0;
    logic [4:0] i_eat_col = 5'd0;
    logic [4:0] i_eat_row = 5'd0;
    logic       o_eat_ready, o_eat_dot, o_eat_pellet, o_dot_clear;
    logic [9:0] o_dots_left;
    logic [4:0] i_rd_col = 5'd0;
    logic [4:0] i_rd_row = 5'd0;
    logic [1:0] o_rd_tile;
`ifdef BOARD_SCORE_EN
    logic [15:0] o_score;
`endif

    board_manager dut (
        .i_clk(clk), .i_rst_n(i_rst_n),
        .i_board_reload(i_board_reload), .o_board_reload_done(o_board_reload_done),
        .o_rom_addr(o_rom_addr), .i_rom_data(rom_data),
        .i_eat_valid(i_eat_valid), .i_eat_col(i_eat_col), .i_eat_row(i_eat_row),
        .o_eat_ready(o_eat_ready), .o_eat_dot(o_eat_dot), .o_eat_pellet(o_eat_pellet),
        .o_dots_left(o_dots_left), .o_dot_clear(o_dot_clear),
        .i_rd_col(i_rd_col), .i_rd_row(i_rd_row), .o_rd_tile(o_rd_tile)
`ifdef BOARD_SCORE_EN
       ,.o_score(o_score)
`endif
    );

    always #5 clk = ~clk;

    logic [1:0] rom [N];
    logic [1:0] mdl [N];
    int         mdl_cnt = 0;
    int         score_mdl = 0;

    always @(posedge clk) rom_data <= rom[int'(o_rom_addr) % N];

    typedef struct { int kind; int cnt; } eat_exp_t;
    eat_exp_t eat_q [$];
    int       load_q [$];
    int       rd_q [$];
    logic     rd_req = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic rel_prev = 1'b0;
        logic load_active = 1'b0;
        int   load_k = 0, sweep_err = 0;
        logic rd_cmp_next = 1'b0, clr_chk = 1'b0, cnt_chk = 1'b0;
        int   clr_exp = 0, exp_cnt = 0, eat_cd = 0, le;
        eat_exp_t e;
        forever begin
            @(negedge clk);
            if (!i_rst_n) begin
                rel_prev = 1'b0; load_active = 1'b0; eat_cd = 0;
                cnt_chk = 1'b0; clr_chk = 1'b0; rd_cmp_next = 1'b0;
            end else begin
                if (rd_cmp_next) begin
                    chk("rd_q_nonempty", rd_q.size() > 0 ? 1 : 0, 1);
                    if (rd_q.size() > 0) chk("rd_tile", int'(o_rd_tile), rd_q.pop_front());
                end
                rd_cmp_next = rd_req;

                if (load_active) begin
                    load_k++;
                    if (load_k <= N && int'(o_rom_addr) != load_k - 1) sweep_err++;
                    if (load_k == 1) chk("dot_clear_in_load", int'(o_dot_clear), 0);
                end
                if (clr_chk) begin
                    chk("dot_clear_after_load", int'(o_dot_clear), clr_exp);
                    clr_chk = 1'b0;
                end
                if (o_board_reload_done) begin
                    if (load_q.size() == 0) begin
                        chk("unexpected_done", int'(o_board_reload_done), 0);
                    end else begin
                        le = load_q.pop_front();
                        chk("done_cycle", load_k, N + 2);
                        chk("rom_addr_sweep_errs", sweep_err, 0);
                        chk("dots_left_at_done", int'(o_dots_left), le);
                        clr_chk = 1'b1;
                        clr_exp = (le == 0) ? 1 : 0;
                        load_active = 1'b0;
                    end
                end
                if (i_board_reload && !rel_prev) begin
                    load_active = 1'b1; load_k = 0; sweep_err = 0;
                end
                rel_prev = i_board_reload;

                if (cnt_chk) begin
                    chk("dots_left_after_eat", int'(o_dots_left), exp_cnt);
                    chk("dot_clear_after_eat", int'(o_dot_clear), exp_cnt == 0 ? 1 : 0);
                    cnt_chk = 1'b0;
                end
                if (eat_cd > 0) begin
                    eat_cd--;
                    if (eat_cd == 0) begin
                        chk("eat_q_nonempty", eat_q.size() > 0 ? 1 : 0, 1);
                        if (eat_q.size() > 0) begin
                            e = eat_q.pop_front();
                            chk("eat_dot", int'(o_eat_dot), e.kind == 1 ? 1 : 0);
                            chk("eat_pellet", int'(o_eat_pellet), e.kind == 2 ? 1 : 0);
                            exp_cnt = e.cnt;
                            cnt_chk = 1'b1;
                        end
                    end
                end else if (o_eat_dot || o_eat_pellet) begin
                    chk("unexpected_eat_pulse", int'(o_eat_dot | o_eat_pellet), 0);
                end
                if (i_eat_valid && load_active) chk("ready_in_load", int'(o_eat_ready), 0);
                if (i_eat_valid && o_eat_ready) eat_cd = 2;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic model_load();
        mdl_cnt = 0;
        for (int a = 0; a < N; a++) begin
            mdl[a] = rom[a];
            if (rom[a] >= 2) mdl_cnt++;
        end
        load_q.push_back(mdl_cnt);
    endtask

    task automatic wait_load();
        for (int i = 0; i < N + 40; i++) begin
            tick();
            if (load_q.size() == 0) break;
        end
        chk("load_pending_after_timeout", load_q.size(), 0);
        load_q.delete();
        tick(); tick();
    endtask

    task automatic do_reload();
        model_load();
        i_board_reload = 1'b1;
        wait_load();
        repeat (5) tick();
        i_board_reload = 1'b0;
        tick();
    endtask

    task automatic eat(input int col, input int row);
        int       kind;
        int       a;
        eat_exp_t e;
        for (int i = 0; i < 20; i++) begin
            if (o_eat_ready) break;
            tick();
        end
        chk("eat_ready", int'(o_eat_ready), 1);
        kind = 0;
        if (col < COLS && row < ROWS) begin
            a = row * COLS + col;
            if (mdl[a] == 2) kind = 1;
            if (mdl[a] == 3) kind = 2;
            if (kind != 0) begin
                mdl[a] = 2'd0;
                if (mdl_cnt > 0) mdl_cnt--;
                score_mdl += (kind == 1) ? 10 : 50;
                if (score_mdl > 65535) score_mdl = 65535;
            end
        end
        e.kind = kind;
        e.cnt  = mdl_cnt;
        eat_q.push_back(e);
        i_eat_valid = 1'b1;
        i_eat_col   = 5'(col);
        i_eat_row   = 5'(row);
        tick();
        i_eat_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic rd_check(input int col, input int row);
        rd_q.push_back((col < COLS && row < ROWS) ? int'(mdl[row * COLS + col]) : 0);
        i_rd_col = 5'(col);
        i_rd_row = 5'(row);
        rd_req   = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_done"},      int'(o_board_reload_done), 0);
        chk({tag, "_rom_addr"},  int'(o_rom_addr), 0);
        chk({tag, "_ready"},     int'(o_eat_ready), 0);
        chk({tag, "_eat_dot"},   int'(o_eat_dot | o_eat_pellet), 0);
        chk({tag, "_dots_left"}, int'(o_dots_left), 0);
        chk({tag, "_dot_clear"}, int'(o_dot_clear), 0);
        chk({tag, "_rd_tile"},   int'(o_rd_tile), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int nd, np, a, a1, a2;

        // Default maze: random walls/empties, 240 dots + 4 pellets, known tiles near origin.
        for (int i = 0; i < N; i++) rom[i] = ($urandom_range(0, 3) == 0) ? 2'd1 : 2'd0;
        rom[0] = 2'd1;
        rom[1 * COLS + 1] = 2'd2;
        rom[3 * COLS + 1] = 2'd3;
        nd = 1; np = 1;
        while (nd < 240) begin
            a = $urandom_range(1, N - 1);
            if (rom[a] < 2) begin rom[a] = 2'd2; nd++; end
        end
        while (np < 4) begin
            a = $urandom_range(1, N - 1);
            if (rom[a] < 2) begin rom[a] = 2'd3; np++; end
        end

        repeat (3) tick();
        chk_all_zero("reset");
        i_rst_n = 1'b1;
        tick();

        // Reset in the middle of a load.
        i_board_reload = 1'b1;
        repeat (50) tick();
        i_rst_n = 1'b0;
        i_board_reload = 1'b0;
        tick();
        chk_all_zero("midload_reset");
        i_rst_n = 1'b1;
        tick();

        // Full load, reload held high afterwards.
        do_reload();

        // Directed eats.
        eat(1, 1);
        rd_check(1, 1);
        eat(1, 1);
        eat(0, 0);
        rd_check(0, 0);
        eat(1, 3);
        rd_check(1, 3);
        eat(30, 2);
        rd_check(29, 31);

        // Randomized eats and renderer reads.
        for (int i = 0; i < 40; i++) begin
            eat($urandom_range(0, 31), $urandom_range(0, 31));
            rd_check($urandom_range(0, 31), $urandom_range(0, 31));
        end

        // Restart mid-load, with an eat attempt while loading.
        model_load();
        i_board_reload = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (o_rom_addr == 10'd100) break;
            tick();
        end
        chk("reached_addr_100", int'(o_rom_addr), 100);
        i_eat_valid = 1'b1;
        i_eat_col = 5'd1;
        i_eat_row = 5'd1;
        i_board_reload = 1'b0;
        tick();
        i_board_reload = 1'b1;
        repeat (3) tick();
        i_eat_valid = 1'b0;
        wait_load();
        i_board_reload = 1'b0;
        tick();
        rd_check(1, 1);

        // Sparse board: one dot and one pellet, cleared by two eats.
        for (int i = 0; i < N; i++) rom[i] = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd0;
        a1 = $urandom_range(0, N - 1);
        a2 = (a1 + $urandom_range(1, N - 1)) % N;
        rom[a1] = 2'd2;
        rom[a2] = 2'd3;
        do_reload();
        eat(a1 % COLS, a1 / COLS);
        eat(a2 % COLS, a2 / COLS);
        do_reload();

`ifdef BOARD_SCORE_EN
        chk("score", int'(o_score), score_mdl);
`endif

        repeat (4) tick();
        chk("eat_q_drained", eat_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
